// File: rtl/gpio_apb_arbiter.sv
// rtl/gpio_apb_arbiter.sv - two-requester APB arbiter and bank decoder for the GPIO bank bus
module gpio_apb_arbiter #(
    parameter int BANK_NUM    = 2,
    parameter int BANK_BITS   = 1,
    parameter int PADDR_WIDTH = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT     = 16
) (
    input  logic                             pclk,
    input  logic                             preset,
    input  logic                             m0_psel,
    input  logic                             m0_penable,
    input  logic                             m0_pwrite,
    input  logic [BANK_BITS+PADDR_WIDTH-1:0] m0_paddr,
    input  logic [DATA_WIDTH-1:0]            m0_pwdata,
    output logic                             m0_pready,
    output logic [DATA_WIDTH-1:0]            m0_prdata,
    output logic                             m0_pslverr,
    input  logic                             m1_psel,
    input  logic                             m1_penable,
    input  logic                             m1_pwrite,
    input  logic [BANK_BITS+PADDR_WIDTH-1:0] m1_paddr,
    input  logic [DATA_WIDTH-1:0]            m1_pwdata,
    output logic                             m1_pready,
    output logic [DATA_WIDTH-1:0]            m1_prdata,
    output logic                             m1_pslverr,
    output logic [BANK_NUM-1:0]              s_pselx,
    output logic                             s_penable,
    output logic                             s_pwrite,
    output logic [PADDR_WIDTH-1:0]           s_paddr,
    output logic [DATA_WIDTH-1:0]            s_pwdata,
    input  logic                             s_pready,
    input  logic [DATA_WIDTH-1:0]            s_prdata,
    output logic                             busy
);
    localparam int AW    = BANK_BITS + PADDR_WIDTH;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t           r_state;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_cnt;

    logic                  w_req;
    logic                  w_grant;
    logic                  w_write;
    logic [AW-1:0]         w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [BANK_BITS-1:0]  w_bank;
    logic                  w_bad_bank;
    logic                  w_finish;
    logic                  w_err;
    logic                  w_resp_grant;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused;

    // A request is psel alone; penable from the requesters carries no meaning here.
    assign w_unused = m0_penable ^ m1_penable;

    always_comb begin
        w_req      = m0_psel | m1_psel;
        w_grant    = (m0_psel && m1_psel) ? ~r_last_grant : m1_psel;
        w_write    = w_grant ? m1_pwrite : m0_pwrite;
        w_addr     = w_grant ? m1_paddr : m0_paddr;
        w_wdata    = w_grant ? m1_pwdata : m0_pwdata;
        w_bank     = w_addr[AW-1:PADDR_WIDTH];
        w_bad_bank = 32'(w_bank) >= 32'(BANK_NUM);
    end

    // Every path into DONE (bad bank, slave ready, timeout) funnels through here.
    always_comb begin
        w_finish     = 1'b0;
        w_err        = 1'b0;
        w_rdata      = '0;
        w_resp_grant = r_last_grant;
        case (r_state)
            IDLE: begin
                if (w_req && w_bad_bank) begin
                    w_finish     = 1'b1;
                    w_err        = 1'b1;
                    w_resp_grant = w_grant;
                end
            end
            ACCESS: begin
                if (s_pready) begin
                    w_finish = 1'b1;
                    w_rdata  = s_pwrite ? '0 : s_prdata;
                end else if (r_cnt == CNT_LAST) begin
                    w_finish = 1'b1;
                    w_err    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            s_pselx      <= '0;
            s_penable    <= 1'b0;
            s_pwrite     <= 1'b0;
            s_paddr      <= '0;
            s_pwdata     <= '0;
            m0_pready    <= 1'b0;
            m0_prdata    <= '0;
            m0_pslverr   <= 1'b0;
            m1_pready    <= 1'b0;
            m1_prdata    <= '0;
            m1_pslverr   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            m0_pready  <= 1'b0;
            m0_prdata  <= '0;
            m0_pslverr <= 1'b0;
            m1_pready  <= 1'b0;
            m1_prdata  <= '0;
            m1_pslverr <= 1'b0;
            if (w_finish) begin
                r_state   <= DONE;
                s_pselx   <= '0;
                s_penable <= 1'b0;
                if (w_resp_grant) begin
                    m1_pready  <= 1'b1;
                    m1_prdata  <= w_rdata;
                    m1_pslverr <= w_err;
                end else begin
                    m0_pready  <= 1'b1;
                    m0_prdata  <= w_rdata;
                    m0_pslverr <= w_err;
                end
            end
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_last_grant <= w_grant;
                        busy         <= 1'b1;
                        if (!w_bad_bank) begin
                            r_state   <= SETUP;
                            s_pselx   <= BANK_NUM'(1) << w_bank;
                            s_penable <= 1'b0;
                            s_pwrite  <= w_write;
                            s_paddr   <= w_addr[PADDR_WIDTH-1:0];
                            s_pwdata  <= w_wdata;
                        end
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    s_penable <= 1'b1;
                    r_cnt     <= '0;
                end
                ACCESS: begin
                    if (!w_finish && r_cnt != CNT_LAST)
                        r_cnt <= r_cnt + 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// tb/tb_gpio_apb_arbiter.sv - self-checking bench for gpio_apb_arbiter
module tb_gpio_apb_arbiter;
    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       m0_psel = 0, m0_penable = 0, m0_pwrite = 0;
    logic [3:0] m0_paddr = 0;
    logic [7:0] m0_pwdata = 0;
    logic       m0_pready, m0_pslverr;
    logic [7:0] m0_prdata;
    logic       m1_psel = 0, m1_penable = 0, m1_pwrite = 0;
    logic [3:0] m1_paddr = 0;
    logic [7:0] m1_pwdata = 0;
    logic       m1_pready, m1_pslverr;
    logic [7:0] m1_prdata;
    logic [1:0] s_pselx;
    logic       s_penable, s_pwrite, busy;
    logic [2:0] s_paddr;
    logic [7:0] s_pwdata;
    logic       s_pready = 0;
    logic [7:0] s_prdata = 8'hEE;

    logic       b_m0_psel = 0, b_m0_pwrite = 0;
    logic [3:0] b_m0_paddr = 0;
    logic [7:0] b_m0_pwdata = 0;
    logic       b_m0_pready, b_m0_pslverr, b_m1_pready, b_m1_pslverr;
    logic [7:0] b_m0_prdata, b_m1_prdata, b_s_pwdata;
    logic [0:0] b_s_pselx;
    logic       b_s_penable, b_s_pwrite, b_busy;
    logic [2:0] b_s_paddr;

    always #5 pclk = ~pclk;

    gpio_apb_arbiter dut (
        .pclk(pclk), .preset(preset),
        .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
        .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata),
        .m0_pready(m0_pready), .m0_prdata(m0_prdata), .m0_pslverr(m0_pslverr),
        .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
        .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata),
        .m1_pready(m1_pready), .m1_prdata(m1_prdata), .m1_pslverr(m1_pslverr),
        .s_pselx(s_pselx), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata),
        .s_pready(s_pready), .s_prdata(s_prdata), .busy(busy)
    );

    gpio_apb_arbiter #(.BANK_NUM(1)) dut_b (
        .pclk(pclk), .preset(preset),
        .m0_psel(b_m0_psel), .m0_penable(b_m0_psel), .m0_pwrite(b_m0_pwrite),
        .m0_paddr(b_m0_paddr), .m0_pwdata(b_m0_pwdata),
        .m0_pready(b_m0_pready), .m0_prdata(b_m0_prdata), .m0_pslverr(b_m0_pslverr),
        .m1_psel(1'b0), .m1_penable(1'b0), .m1_pwrite(1'b0),
        .m1_paddr(4'h0), .m1_pwdata(8'h00),
        .m1_pready(b_m1_pready), .m1_prdata(b_m1_prdata), .m1_pslverr(b_m1_pslverr),
        .s_pselx(b_s_pselx), .s_penable(b_s_penable), .s_pwrite(b_s_pwrite),
        .s_paddr(b_s_paddr), .s_pwdata(b_s_pwdata),
        .s_pready(1'b1), .s_prdata(8'h00), .busy(b_busy)
    );

    typedef struct {
        bit         id;
        logic [1:0] sel;
        logic [2:0] paddr;
        logic       write;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    typedef struct {
        bit         who;
        logic       write;
        logic [3:0] addr;
        logic [7:0] wdata;
        int         rdy;
        logic [7:0] srd;
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   total = 0;
    int   bad = 0;
    int   slv_rdy = 1;
    logic [7:0] slv_rdata = 8'h00;
    int   acc_idx = 0;
    exp_t mon_e;
    bit   mon_id;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave bank: ready on the slv_rdy-th ACCESS cycle (0 = never), garbage data otherwise.
    always @(negedge pclk) begin
        if (|s_pselx && s_penable) begin
            acc_idx++;
            if (acc_idx == 1) begin
                if (sb.size() == 0) check("access_without_expect", 1, 0);
                else begin
                    check("acc_pselx", s_pselx, sb[0].sel);
                    check("acc_paddr", s_paddr, sb[0].paddr);
                    check("acc_pwrite", s_pwrite, sb[0].write);
                    if (sb[0].write) check("acc_pwdata", s_pwdata, sb[0].wdata);
                end
            end
            s_pready = (slv_rdy != 0) && (acc_idx == slv_rdy);
            s_prdata = s_pready ? slv_rdata : 8'hEE;
        end else begin
            acc_idx  = 0;
            s_pready = 1'b0;
            s_prdata = 8'hEE;
        end
    end

    always @(negedge pclk) begin
        if (!m0_pready) check("m0_quiet", {m0_prdata, m0_pslverr}, 0);
        if (!m1_pready) check("m1_quiet", {m1_prdata, m1_pslverr}, 0);
        if (m0_pready && m1_pready) check("both_pready", 1, 0);
        else if (m0_pready || m1_pready) begin
            mon_id = m1_pready;
            if (sb.size() == 0) check("unexpected_pready", 1, 0);
            else begin
                mon_e = sb.pop_front();
                check("grant_id", mon_id, mon_e.id);
                check("prdata", mon_id ? m1_prdata : m0_prdata, mon_e.rdata);
                check("pslverr", mon_id ? m1_pslverr : m0_pslverr, mon_e.err);
                check("done_slave_idle", {s_pselx, s_penable}, 0);
            end
        end
    end

    task automatic drive(input bit who, input logic psel, input logic wr,
                         input logic [3:0] a, input logic [7:0] d);
        if (who) begin
            m1_psel = psel; m1_penable = psel; m1_pwrite = wr; m1_paddr = a; m1_pwdata = d;
        end else begin
            m0_psel = psel; m0_penable = psel; m0_pwrite = wr; m0_paddr = a; m0_pwdata = d;
        end
    endtask

    task automatic push(input bit who, input logic wr, input logic [3:0] a,
                        input logic [7:0] d, input logic [7:0] rd, input logic er);
        exp_t e;
        e.id = who; e.sel = a[3] ? 2'b10 : 2'b01; e.paddr = a[2:0];
        e.write = wr; e.wdata = d; e.rdata = rd; e.err = er;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin @(negedge pclk); n++; end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    task automatic wait_pready(input int start, output int lat, output bit who);
        lat = start;
        while (!(m0_pready || m1_pready) && lat < 60) begin @(negedge pclk); lat++; end
        who = m1_pready;
        if (!(m0_pready || m1_pready)) check("pready_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge pclk); preset = 1'b1;
        @(negedge pclk); preset = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pselx"}, s_pselx, 0);
        check({tag, "_penable"}, s_penable, 0);
        check({tag, "_pwrite"}, s_pwrite, 0);
        check({tag, "_paddr"}, s_paddr, 0);
        check({tag, "_pwdata"}, s_pwdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_m0"}, {m0_pready, m0_prdata, m0_pslverr}, 0);
        check({tag, "_m1"}, {m1_pready, m1_prdata, m1_pslverr}, 0);
    endtask

    initial begin
        int  lat;
        bit  who;
        int  pulses;
        int  cnt;
        vecs[0] = '{0, 1'b1, 4'h3, 8'hA5, 1,  8'h00, 8'h00, 1'b0, 3};
        vecs[1] = '{1, 1'b0, 4'hD, 8'h00, 3,  8'h3C, 8'h3C, 1'b0, 5};
        vecs[2] = '{0, 1'b0, 4'h2, 8'h00, 0,  8'h55, 8'h00, 1'b1, 18};
        vecs[3] = '{1, 1'b1, 4'h9, 8'h5A, 2,  8'hFF, 8'h00, 1'b0, 4};
        vecs[4] = '{0, 1'b0, 4'hF, 8'h00, 1,  8'h81, 8'h81, 1'b0, 3};
        vecs[5] = '{1, 1'b0, 4'h0, 8'h00, 16, 8'h77, 8'h77, 1'b0, 18};

        repeat (2) @(negedge pclk);
        check_zero("rst");
        preset = 1'b0;

        foreach (vecs[i]) begin
            wait_idle();
            slv_rdy = vecs[i].rdy; slv_rdata = vecs[i].srd;
            push(vecs[i].who, vecs[i].write, vecs[i].addr, vecs[i].wdata,
                 vecs[i].exp_rdata, vecs[i].exp_err);
            drive(vecs[i].who, 1'b1, vecs[i].write, vecs[i].addr, vecs[i].wdata);
            @(negedge pclk);
            drive(vecs[i].who, 1'b0, ~vecs[i].write, ~vecs[i].addr, ~vecs[i].wdata);
            wait_pready(1, lat, who);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_who", i), who, vecs[i].who);
        end

        // Continuous simultaneous requests alternate with one IDLE cycle between transfers.
        wait_idle();
        do_reset();
        slv_rdy = 1; slv_rdata = 8'h11;
        for (int k = 0; k < 4; k++)
            push(k[0], 1'b0, k[0] ? 4'hA : 4'h1, 8'h00, 8'h11, 1'b0);
        drive(0, 1'b1, 1'b0, 4'h1, 8'h00);
        drive(1, 1'b1, 1'b0, 4'hA, 8'h00);
        pulses = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge pclk);
            check($sformatf("alt_busy_c%0d", c), busy, (c % 4) != 0);
            check($sformatf("alt_pulse_c%0d", c), m0_pready | m1_pready, (c % 4) == 3);
            if (m0_pready | m1_pready) begin
                check($sformatf("alt_order_%0d", pulses), m1_pready, pulses % 2);
                pulses++;
            end
            if (c == 15) begin
                drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
                drive(1, 1'b0, 1'b0, 4'h0, 8'h00);
            end
        end

        // Reset during m1 ACCESS: everything clears and no completion is issued.
        wait_idle();
        slv_rdy = 0;
        push(1, 1'b0, 4'hC, 8'h99, 8'h00, 1'b0);
        drive(1, 1'b1, 1'b0, 4'hC, 8'h99);
        @(negedge pclk);
        drive(1, 1'b0, 1'b0, 4'h0, 8'h00);
        repeat (2) @(negedge pclk);
        check("midrst_in_access", {s_pselx, s_penable}, 3'b101);
        preset = 1'b1;
        @(negedge pclk);
        check_zero("midrst");
        preset = 1'b0;
        sb.delete();
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge pclk);
            if (m1_pready) cnt++;
        end
        check("midrst_no_pready", cnt, 0);

        slv_rdy = 1; slv_rdata = 8'h42;
        push(0, 1'b0, 4'h6, 8'h00, 8'h42, 1'b0);
        drive(0, 1'b1, 1'b0, 4'h6, 8'h00);
        drive(1, 1'b1, 1'b0, 4'hB, 8'h00);
        @(negedge pclk);
        drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
        drive(1, 1'b0, 1'b0, 4'h0, 8'h00);
        wait_pready(1, lat, who);
        check("postrst_first_grant", who, 0);
        check("postrst_latency", lat, 3);
        wait_idle();

        // Single-bank instance: bank index 1 errors out without touching the slave.
        b_m0_psel = 1'b1; b_m0_pwrite = 1'b1; b_m0_paddr = 4'h9; b_m0_pwdata = 8'h33;
        @(negedge pclk);
        b_m0_psel = 1'b0;
        check("bb_pready", b_m0_pready, 1);
        check("bb_pslverr", b_m0_pslverr, 1);
        check("bb_prdata", b_m0_prdata, 0);
        check("bb_pselx", {b_s_pselx, b_s_penable}, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge pclk);
            check("bb_after", {b_s_pselx, b_s_penable, b_m0_pready}, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gpio_apb_arbiter.md
Name: gpio_apb_arbiter

Overview:
Two-requester APB arbiter and bank decoder in front of the GPIO bank (gbas) APB bus. Requester 0 is the SPI-to-APB bridge. Requester 1 is an on-chip agent such as an input poller or debouncer. The block serialises both requesters onto one shared APB master, decodes bank index to one-hot pselx, and guards every access with a pready timeout.

Parameters:
BANK_NUM, 2, number of GPIO banks (pselx width)
BANK_BITS, 1, requester address bits selecting the bank
PADDR_WIDTH, 3, register address width inside a bank
DATA_WIDTH, 8, APB data width
TIMEOUT, 16, max ACCESS cycles waiting for s_pready before abort (>=2)

Ports:
pclk  in  1  APB clock, all logic on rising edge
preset  in  1  synchronous active-high reset
m0_psel  in  1  requester 0 select
m0_penable  in  1  requester 0 enable
m0_pwrite  in  1  requester 0 write=1/read=0
m0_paddr  in  BANK_BITS+PADDR_WIDTH  {bank, reg} address
m0_pwdata  in  DATA_WIDTH  write data
m0_pready  out  1  one-cycle completion pulse
m0_prdata  out  DATA_WIDTH  read data, valid with m0_pready
m0_pslverr  out  1  error, valid with m0_pready
m1_*  same set as m0_*  requester 1
s_pselx  out  BANK_NUM  one-hot bank select
s_penable  out  1  shared APB enable
s_pwrite  out  1  shared write
s_paddr  out  PADDR_WIDTH  register address
s_pwdata  out  DATA_WIDTH  write data
s_pready  in  1  shared bank ready
s_prdata  in  DATA_WIDTH  shared bank read data
busy  out  1  high in any state but IDLE

Behaviour:
- Reset (preset=1 at an edge):
  - State becomes IDLE and last_grant becomes 1, so requester 0 wins the first tie.
  - All outputs become 0: s_pselx, s_penable, s_pwrite, s_paddr, s_pwdata, mX_pready, mX_prdata, mX_pslverr, busy.
  - Reset mid-transfer aborts silently; no mX_pready pulse is issued.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - A request is mX_psel=1; mX_penable is not required.
  - With no request, stay in IDLE.
  - With one request, grant it.
  - With both requesting, grant the requester != last_grant.
  - On grant: latch pwrite, paddr and pwdata from the winner into internal registers, and update last_grant.
  - Bank index >= BANK_NUM: go to DONE with err=1 and rdata=0; no slave access occurs.
  - Valid bank: go to SETUP.
- SETUP:
  - s_pselx[bank]=1, s_penable=0, address/write/data driven from the latched registers.
  - Always moves to ACCESS next cycle.
- ACCESS:
  - s_pselx held, s_penable=1, timeout counter increments each cycle.
  - s_pready=1 sampled: capture s_prdata (reads only; writes return 0) with err=0, then go to DONE.
  - Counter reaches TIMEOUT-1 without s_pready: go to DONE with err=1 and rdata=0.
- DONE:
  - s_pselx=0 and s_penable=0.
  - The granted requester sees mX_pready=1 with mX_prdata and mX_pslverr for exactly one cycle.
  - The other requester's outputs stay 0.
  - Next state is IDLE.
- Outputs to requesters are 0 in every cycle except DONE.
- Slave bus outputs hold their last values outside SETUP/ACCESS; only s_pselx and s_penable are forced to 0.
- Latency: request seen in IDLE at cycle N gives SETUP at N+1 and ACCESS at N+2. With zero-wait s_pready, mX_pready is at N+3 and IDLE at N+4, so a minimum of 4 cycles per transfer.
- Back-to-back: a requester may be re-granted on the IDLE cycle after DONE. With both requesting continuously, grants alternate 0,1,0,1.
- Requester inputs are ignored after grant. Changing or dropping psel mid-transfer does not alter the transfer, and the DONE pulse is still issued.
- The timeout counter clears on entry to ACCESS.
- The counter is $clog2(TIMEOUT) bits wide and saturates rather than wraps.

Test Plan:
- Reset then single write: m0 writes {bank0, reg 3} with data 0xA5, s_pready tied 1.
  - -> s_pselx=01 at N+1, s_penable=1 at N+2, m0_pready pulse at N+3 with pslverr=0.
  - -> s_paddr=3 and s_pwdata=0xA5 throughout.
- Read with wait states: m1 reads {bank1, reg 5}, s_pready asserted on the 3rd ACCESS cycle with s_prdata=0x3C.
  - -> s_pselx=10.
  - -> m1_pready=1 with m1_prdata=0x3C exactly one cycle after s_pready is sampled.
  - -> m0 outputs stay 0.
- Simultaneous requests after reset: m0 and m1 request continuously.
  - -> grant order 0,1,0,1.
  - -> each transfer takes 4 cycles; busy drops for exactly 1 IDLE cycle between transfers.
- Timeout: s_pready tied 0, m0 reads bank0.
  - -> ACCESS lasts TIMEOUT=16 cycles.
  - -> m0_pready=1 with pslverr=1 and prdata=0x00.
  - -> s_pselx returns to 0.
- Bad bank: BANK_NUM=1, m0 accesses bank index 1.
  - -> s_pselx never asserts.
  - -> m0_pready with pslverr=1 on the cycle after the IDLE grant.
- Reset mid-ACCESS: assert preset during m1 ACCESS.
  - -> next cycle all outputs are 0, with no m1_pready pulse.
  - -> a subsequent simultaneous request grants m0 first.
